// File: rtl/mux_sel_skid_if.sv
// ---------------------------------------------------------------------------
// mux_sel_skid_if
// Handshake and data bundle for the mux_sel_skid source selector.
//
// Signals
//   data_i     N_SRC*WIDTH  source channels, channel k at [k*WIDTH +: WIDTH]
//   selector   SEL_W        source code, meaningful only with in_valid
//   in_valid   1            producer offers a selection
//   in_ready   1            selector can take a selection this cycle
//   data_o     WIDTH        registered selected value
//   out_valid  1            data_o holds an undelivered result
//   out_ready  1            consumer takes data_o this cycle
//   sel_err    1            sticky flag: an out-of-range code was accepted
//   clr_err    1            synchronous clear of sel_err
//
// Modports
//   master  producer/consumer side (drives requests, out_ready, clr_err)
//   slave   the selector itself
// ---------------------------------------------------------------------------
interface mux_sel_skid_if #(
    parameter int WIDTH = 32,
    parameter int N_SRC = 3,
    parameter int SEL_W = 2
);
    logic [N_SRC*WIDTH-1:0] data_i;
    logic [SEL_W-1:0]       selector;
    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       data_o;
    logic                   out_valid;
    logic                   out_ready;
    logic                   sel_err;
    logic                   clr_err;

    modport master (
        output data_i, selector, in_valid, out_ready, clr_err,
        input  in_ready, data_o, out_valid, sel_err
    );

    modport slave (
        input  data_i, selector, in_valid, out_ready, clr_err,
        output in_ready, data_o, out_valid, sel_err
    );
endinterface

// File: rtl/mux_sel_skid.sv
// ---------------------------------------------------------------------------
// mux_sel_skid
// N-source selector with one constant input, a registered output stage and a
// one-entry skid buffer so a stalled consumer can back-pressure the producer
// without losing a selection that was already accepted.
//
// Code map: 0 -> channel 0, 1 -> CONST_VAL, 2..N_SRC -> channel code-1,
//           anything above N_SRC -> 0 and raises the sticky sel_err flag.
//
// Ports
//   clk    in  rising-edge clock
//   reset  in  asynchronous reset, active-low
//   bus    slave modport of mux_sel_skid_if (request, result, error flag)
// ---------------------------------------------------------------------------
module mux_sel_skid #(
    parameter int               WIDTH     = 32,
    parameter int               N_SRC     = 3,
    parameter int               SEL_W     = 2,
    parameter logic [WIDTH-1:0] CONST_VAL = WIDTH'(4)
) (
    input  logic          clk,
    input  logic          reset,
    mux_sel_skid_if.slave bus
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    localparam logic [SEL_W-1:0] LP_MAX_CODE = SEL_W'(N_SRC);

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_data_out;
    logic [WIDTH-1:0] r_skid_data;
    logic             r_sel_err;
    logic [WIDTH-1:0] w_sel_value;
    logic             w_accept;
    logic             w_pop;
    logic             w_bad_code;

    // Handshake flags decode straight from the state register, so in_ready
    // never combinationally depends on out_ready.
    assign bus.in_ready  = (r_state != TWO);
    assign bus.out_valid = (r_state != EMPTY);
    assign bus.data_o    = r_data_out;
    assign bus.sel_err   = r_sel_err;

    assign w_accept   = bus.in_valid & bus.in_ready;
    assign w_pop      = bus.out_valid & bus.out_ready;
    assign w_bad_code = (bus.selector > LP_MAX_CODE);

    // Source selection; out-of-range codes fall through to zero.
    always_comb begin
        w_sel_value = '0;
        if (bus.selector == '0) begin
            w_sel_value = bus.data_i[0 +: WIDTH];
        end else if (bus.selector == SEL_W'(1)) begin
            w_sel_value = CONST_VAL;
        end else begin
            for (int k = 2; k <= N_SRC; k++) begin
                if (bus.selector == SEL_W'(k)) begin
                    w_sel_value = bus.data_i[(k-1)*WIDTH +: WIDTH];
                end
            end
        end
    end

    // Next-state logic for the two-entry occupancy tracker.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            EMPTY: begin
                if (w_accept) w_next_state = ONE;
            end
            ONE: begin
                if (w_pop && !w_accept)      w_next_state = EMPTY;
                else if (!w_pop && w_accept) w_next_state = TWO;
            end
            TWO: begin
                if (w_pop) w_next_state = ONE;
            end
            default: w_next_state = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Data path: a new selection lands in the output register whenever that
    // register is free or being drained, otherwise it parks in the skid entry.
    // The skid entry drains into the output register on a pop from TWO.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_data_out  <= '0;
            r_skid_data <= '0;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_accept) r_data_out <= w_sel_value;
                end
                ONE: begin
                    if (w_accept && w_pop)       r_data_out  <= w_sel_value;
                    else if (w_accept && !w_pop) r_skid_data <= w_sel_value;
                end
                TWO: begin
                    if (w_pop) r_data_out <= r_skid_data;
                end
                default: begin
                    r_data_out <= r_data_out;
                end
            endcase
        end
    end

    // Sticky error flag; a bad accept in the same cycle beats the clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sel_err <= 1'b0;
        end else if (w_accept && w_bad_code) begin
            r_sel_err <= 1'b1;
        end else if (bus.clr_err) begin
            r_sel_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_sel_skid.sv
// ---------------------------------------------------------------------------
// tb_mux_sel_skid
// Drives two selector instances (three sources and two sources) from one
// shared request stream and compares both against a queue-based model every
// cycle, with hand-computed expectations on the directed scenarios.
// ---------------------------------------------------------------------------
module tb_mux_sel_skid;

    logic        clk;
    logic        reset;
    logic [95:0] dataIn;
    logic [1:0]  sel;
    logic        inValid;
    logic        outReady;
    logic        clrErr;

    int total = 0;
    int bad   = 0;

    mux_sel_skid_if #(.WIDTH(32), .N_SRC(3), .SEL_W(2)) bus1 ();
    mux_sel_skid_if #(.WIDTH(32), .N_SRC(2), .SEL_W(2)) bus2 ();

    assign bus1.data_i    = dataIn;
    assign bus1.selector  = sel;
    assign bus1.in_valid  = inValid;
    assign bus1.out_ready = outReady;
    assign bus1.clr_err   = clrErr;

    assign bus2.data_i    = dataIn[63:0];
    assign bus2.selector  = sel;
    assign bus2.in_valid  = inValid;
    assign bus2.out_ready = outReady;
    assign bus2.clr_err   = clrErr;

    mux_sel_skid #(.WIDTH(32), .N_SRC(3), .SEL_W(2), .CONST_VAL(32'd4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    mux_sel_skid #(.WIDTH(32), .N_SRC(2), .SEL_W(2), .CONST_VAL(32'd4)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: each instance is a FIFO of at most two results.
    logic [31:0] q1[$];
    logic [31:0] q2[$];
    logic        err1;
    logic        err2;

    function automatic logic [31:0] mapCode(int nsrc, int code, logic [95:0] d);
        if (code == 0)    return d[31:0];
        if (code == 1)    return 32'd4;
        if (code <= nsrc) return d[(code-1)*32 +: 32];
        return 32'd0;
    endfunction

    task automatic checkOutput(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update on every clock edge (inputs are stable there) and on reset.
    initial begin
        q1.delete(); q2.delete(); err1 = 1'b0; err2 = 1'b0;
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                q1.delete(); q2.delete(); err1 = 1'b0; err2 = 1'b0;
            end else begin
                bit acc1, acc2, pop1, pop2;
                acc1 = inValid && (q1.size() < 2);
                acc2 = inValid && (q2.size() < 2);
                pop1 = outReady && (q1.size() > 0);
                pop2 = outReady && (q2.size() > 0);
                if (pop1) void'(q1.pop_front());
                if (pop2) void'(q2.pop_front());
                if (acc1) q1.push_back(mapCode(3, int'(sel), dataIn));
                if (acc2) q2.push_back(mapCode(2, int'(sel), dataIn));
                if (acc1 && int'(sel) > 3) err1 = 1'b1;
                else if (clrErr)           err1 = 1'b0;
                if (acc2 && int'(sel) > 2) err2 = 1'b1;
                else if (clrErr)           err2 = 1'b0;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            checkOutput("cmpReady1", bus1.in_ready,  q1.size() < 2);
            checkOutput("cmpValid1", bus1.out_valid, q1.size() > 0);
            checkOutput("cmpErr1",   bus1.sel_err,   err1);
            if (q1.size() > 0) checkOutput("cmpData1", bus1.data_o, q1[0]);
            checkOutput("cmpReady2", bus2.in_ready,  q2.size() < 2);
            checkOutput("cmpValid2", bus2.out_valid, q2.size() > 0);
            checkOutput("cmpErr2",   bus2.sel_err,   err2);
            if (q2.size() > 0) checkOutput("cmpData2", bus2.data_o, q2[0]);
        end
    end

    // Holds the given inputs across exactly one rising edge.
    task automatic applyStimulus(logic v, logic [1:0] s, logic r, logic c);
        inValid  = v;
        sel      = s;
        outReady = r;
        clrErr   = c;
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic [31:0] expVal;
        reset    = 1'b0;
        dataIn   = {32'hC, 32'hB, 32'hA};
        sel      = 2'd0;
        inValid  = 1'b0;
        outReady = 1'b0;
        clrErr   = 1'b0;

        // Reset values without any clock edge
        #1;
        checkOutput("rstValid", bus1.out_valid, 1'b0);
        checkOutput("rstData",  bus1.data_o,    32'h0);
        checkOutput("rstReady", bus1.in_ready,  1'b1);
        checkOutput("rstErr",   bus1.sel_err,   1'b0);
        #6 reset = 1'b1;
        @(posedge clk); #2;

        // Code map, back-to-back with out_ready high
        applyStimulus(1, 2'd0, 1, 0);
        checkOutput("map0", bus1.data_o, 32'hA);
        checkOutput("map0v", bus1.out_valid, 1'b1);
        applyStimulus(1, 2'd1, 1, 0);
        checkOutput("map1", bus1.data_o, 32'h4);
        applyStimulus(1, 2'd2, 1, 0);
        checkOutput("map2", bus1.data_o, 32'hB);
        applyStimulus(1, 2'd3, 1, 0);
        checkOutput("map3", bus1.data_o, 32'hC);
        checkOutput("map3v", bus1.out_valid, 1'b1);
        checkOutput("map3bad2", bus2.data_o, 32'h0);
        applyStimulus(0, 2'd0, 1, 0);
        checkOutput("mapDrain", bus1.out_valid, 1'b0);

        // Back-pressure into the skid entry
        applyStimulus(1, 2'd0, 0, 0);
        checkOutput("bpOneReady", bus1.in_ready, 1'b1);
        applyStimulus(1, 2'd2, 0, 0);
        checkOutput("bpTwoReady", bus1.in_ready, 1'b0);
        checkOutput("bpTwoData",  bus1.data_o,   32'hA);
        applyStimulus(1, 2'd1, 0, 0);
        checkOutput("bpHoldData", bus1.data_o,   32'hA);
        applyStimulus(0, 2'd0, 1, 0);
        checkOutput("bpPopData",  bus1.data_o,   32'hB);
        checkOutput("bpPopReady", bus1.in_ready, 1'b1);
        applyStimulus(0, 2'd0, 1, 0);
        checkOutput("bpEmpty",    bus1.out_valid, 1'b0);

        // Streaming with simultaneous push and pop
        for (int i = 0; i < 8; i++) begin
            dataIn[31:0] = 32'h100 + 32'(i);
            applyStimulus(1, 2'(i % 4), 1, 0);
            case (i % 4)
                0:       expVal = 32'h100 + 32'(i);
                1:       expVal = 32'h4;
                2:       expVal = 32'hB;
                default: expVal = 32'hC;
            endcase
            checkOutput("streamData",  bus1.data_o,   expVal);
            checkOutput("streamReady", bus1.in_ready, 1'b1);
        end
        applyStimulus(0, 2'd0, 1, 0);
        dataIn[31:0] = 32'hA;

        // Sticky error on the two-source instance
        checkOutput("errSticky", bus2.sel_err, 1'b1);
        applyStimulus(0, 2'd0, 1, 1);
        checkOutput("errClr", bus2.sel_err, 1'b0);
        applyStimulus(1, 2'd3, 1, 0);
        checkOutput("errSet",      bus2.sel_err, 1'b1);
        checkOutput("errSetData",  bus2.data_o,  32'h0);
        checkOutput("errNoSet3",   bus1.sel_err, 1'b0);
        applyStimulus(0, 2'd0, 1, 0);
        checkOutput("errHold", bus2.sel_err, 1'b1);
        applyStimulus(0, 2'd0, 1, 1);
        checkOutput("errClr2", bus2.sel_err, 1'b0);
        applyStimulus(1, 2'd3, 1, 1);
        checkOutput("errSetWins", bus2.sel_err, 1'b1);
        applyStimulus(0, 2'd0, 1, 0);

        // Reset while both entries are occupied
        applyStimulus(1, 2'd0, 0, 0);
        applyStimulus(1, 2'd2, 0, 0);
        checkOutput("preRstReady", bus1.in_ready, 1'b0);
        reset = 1'b0;
        #1;
        checkOutput("midRstValid", bus1.out_valid, 1'b0);
        checkOutput("midRstData",  bus1.data_o,    32'h0);
        checkOutput("midRstReady", bus1.in_ready,  1'b1);
        checkOutput("midRstErr2",  bus2.sel_err,   1'b0);
        inValid = 1'b0;
        #1 reset = 1'b1;
        applyStimulus(1, 2'd1, 1, 0);
        checkOutput("postRstData",  bus1.data_o,    32'h4);
        checkOutput("postRstValid", bus1.out_valid, 1'b1);
        applyStimulus(0, 2'd0, 1, 0);
        checkOutput("postRstEmpty", bus1.out_valid, 1'b0);
        applyStimulus(0, 2'd0, 1, 0);

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
